// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - 32-bit MIPS execute-stage ALU with a sticky overflow register.
// Optional feature macro: ALU_CMP_EN (compare group).
module mips_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [5:0]  ALUFun,
   input  logic        Sign,
   output logic [31:0] Z,
   output logic        S,
   output logic        V,
   output logic        OvfSticky
);

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_AND = 6'b011000;
   localparam logic [5:0] OP_OR  = 6'b011110;
   localparam logic [5:0] OP_XOR = 6'b010110;
   localparam logic [5:0] OP_NOR = 6'b010001;
   localparam logic [5:0] OP_PSA = 6'b011010;
   localparam logic [5:0] OP_SLL = 6'b100000;
   localparam logic [5:0] OP_SRL = 6'b100001;
   localparam logic [5:0] OP_SRA = 6'b100011;
`ifdef ALU_CMP_EN
   localparam logic [5:0] OP_EQ  = 6'b110011;
   localparam logic [5:0] OP_NEQ = 6'b110001;
   localparam logic [5:0] OP_LT  = 6'b110101;
   localparam logic [5:0] OP_LEZ = 6'b111101;
   localparam logic [5:0] OP_LTZ = 6'b111011;
   localparam logic [5:0] OP_GTZ = 6'b111111;
`endif

   logic [32:0] sum;
   logic [32:0] diff;
   logic        add_ovf_s;
   logic        sub_ovf_s;
   logic        borrow;
   logic [4:0]  shamt;
   logic [31:0] sra_res;

   // 33-bit forms expose carry-out of ADD and borrow of SUB in bit 32.
   assign sum       = {1'b0, A} + {1'b0, B};
   assign diff      = {1'b0, A} - {1'b0, B};
   assign borrow    = diff[32];
   assign add_ovf_s = (A[31] == B[31]) && (sum[31] != A[31]);
   assign sub_ovf_s = (A[31] != B[31]) && (diff[31] != A[31]);
   assign shamt     = A[4:0];
   assign sra_res   = $signed(B) >>> shamt;

`ifdef ALU_CMP_EN
   logic a_zero;
   logic lt_flag;

   assign a_zero  = (A == 32'd0);
   assign lt_flag = Sign ? ($signed(A) < $signed(B)) : (A < B);
`endif

   always_comb begin
      Z = 32'd0;
      S = 1'b0;
      V = 1'b0;
      case (ALUFun)
         OP_ADD: begin
            Z = sum[31:0];
            V = Sign ? add_ovf_s : sum[32];
            S = Sign ? sum[31] : 1'b0;
         end
         OP_SUB: begin
            Z = diff[31:0];
            V = Sign ? sub_ovf_s : borrow;
            S = Sign ? diff[31] : borrow;
         end
         OP_AND: Z = A & B;
         OP_OR:  Z = A | B;
         OP_XOR: Z = A ^ B;
         OP_NOR: Z = ~(A | B);
         OP_PSA: Z = A;
         OP_SLL: Z = B << shamt;
         OP_SRL: Z = B >> shamt;
         OP_SRA: Z = sra_res;
`ifdef ALU_CMP_EN
         OP_EQ:  Z = {31'd0, (A == B)};
         OP_NEQ: Z = {31'd0, (A != B)};
         OP_LT:  Z = {31'd0, lt_flag};
         OP_LEZ: Z = {31'd0, (A[31] | a_zero)};
         OP_LTZ: Z = {31'd0, A[31]};
         OP_GTZ: Z = {31'd0, (~A[31] & ~a_zero)};
`endif
         default: begin
            Z = 32'd0;
            S = 1'b0;
            V = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         OvfSticky <= 1'b0;
      else if ((ALUFun[5:4] == 2'b00) && V)
         OvfSticky <= 1'b1;
   end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - directed-vector self-checking bench for mips_alu.
module tb_mips_alu;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [5:0]  ALUFun;
   logic        Sign;
   logic [31:0] Z;
   logic        S;
   logic        V;
   logic        OvfSticky;

   int vectors;
   int miscompares;

   mips_alu dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .ALUFun    (ALUFun),
      .Sign      (Sign),
      .Z         (Z),
      .S         (S),
      .V         (V),
      .OvfSticky (OvfSticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] fun, input logic sgn);
      A      = a;
      B      = b;
      ALUFun = fun;
      Sign   = sgn;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      apply(32'd0, 32'd0, 6'b011010, 1'b0);
      #3;
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL reset_sticky got=%b exp=0", OvfSticky);
         miscompares++;
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_logic;
      logic [5:0]  codes [6];
      logic [31:0] exps  [6];
      codes = '{6'b011000, 6'b011110, 6'b010110, 6'b010001, 6'b011010, 6'b011111};
      exps  = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'hF0F0F0F0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         apply(32'hF0F0F0F0, 32'hFF00FF00, codes[i], 1'b1);
         vectors++;
         if (Z !== exps[i] || S !== 1'b0 || V !== 1'b0) begin
            $display("FAIL logic_%b got Z=%h S=%b V=%b exp Z=%h S=0 V=0", codes[i], Z, S, V, exps[i]);
            miscompares++;
         end
      end
      @(posedge clk);
      #1;
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL logic_sticky got=%b exp=0", OvfSticky);
         miscompares++;
      end
   endtask

   task automatic test_shift;
      @(negedge clk);
      apply(32'h8000001D, 32'h80000001, 6'b100000, 1'b0);
      vectors++;
      if (Z !== 32'h20000000 || S !== 1'b0 || V !== 1'b0) begin
         $display("FAIL sll got Z=%h S=%b V=%b exp Z=20000000", Z, S, V);
         miscompares++;
      end
      apply(32'h40000003, 32'h80000001, 6'b100001, 1'b0);
      vectors++;
      if (Z !== 32'h10000000) begin
         $display("FAIL srl got=%h exp=10000000", Z);
         miscompares++;
      end
      apply(32'h40000003, 32'h80000001, 6'b100011, 1'b0);
      vectors++;
      if (Z !== 32'hF0000000) begin
         $display("FAIL sra got=%h exp=F0000000", Z);
         miscompares++;
      end
      apply(32'hFFFFFFE0, 32'h80000001, 6'b100011, 1'b0);
      vectors++;
      if (Z !== 32'h80000001) begin
         $display("FAIL sra_shamt0 got=%h exp=80000001", Z);
         miscompares++;
      end
   endtask

   task automatic test_compare;
      logic [5:0]  codes [8];
      logic [31:0] as    [8];
      logic [31:0] bs    [8];
      logic        sgns  [8];
      logic [31:0] exps  [8];
      codes = '{6'b110011, 6'b110001, 6'b110101, 6'b110101, 6'b111101, 6'b111011, 6'b111111, 6'b111011};
      as    = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
      bs    = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      sgns  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef ALU_CMP_EN
      exps  = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
`else
      exps  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         apply(as[i], bs[i], codes[i], sgns[i]);
         vectors++;
         if (Z !== exps[i] || S !== 1'b0 || V !== 1'b0) begin
            $display("FAIL cmp_%0d_%b got Z=%h S=%b V=%b exp Z=%h", i, codes[i], Z, S, V, exps[i]);
            miscompares++;
         end
      end
   endtask

   task automatic test_add_overflow;
      @(negedge clk);
      apply(32'h00000005, 32'h00000003, 6'b000000, 1'b1);
      vectors++;
      if (Z !== 32'h8 || V !== 1'b0 || S !== 1'b0) begin
         $display("FAIL add_plain got Z=%h V=%b S=%b exp Z=8 V=0 S=0", Z, V, S);
         miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL add_plain_sticky got=%b exp=0", OvfSticky);
         miscompares++;
      end
      @(negedge clk);
      apply(32'h7FFFFFFF, 32'h7FFFFFFF, 6'b000000, 1'b1);
      vectors++;
      if (Z !== 32'hFFFFFFFE || V !== 1'b1 || S !== 1'b1) begin
         $display("FAIL add_ovf got Z=%h V=%b S=%b exp Z=FFFFFFFE V=1 S=1", Z, V, S);
         miscompares++;
      end
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL add_ovf_pre_edge got=%b exp=0", OvfSticky);
         miscompares++;
      end
      @(posedge clk);
      #1;
      apply(32'd0, 32'd0, 6'b011010, 1'b0);
      vectors++;
      if (OvfSticky !== 1'b1) begin
         $display("FAIL add_ovf_sticky got=%b exp=1", OvfSticky);
         miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (OvfSticky !== 1'b1) begin
         $display("FAIL sticky_hold got=%b exp=1", OvfSticky);
         miscompares++;
      end
   endtask

   task automatic test_sub;
      @(negedge clk);
      apply(32'd1, 32'd2, 6'b000001, 1'b0);
      vectors++;
      if (Z !== 32'hFFFFFFFF || V !== 1'b1 || S !== 1'b1) begin
         $display("FAIL sub_unsigned got Z=%h V=%b S=%b exp Z=FFFFFFFF V=1 S=1", Z, V, S);
         miscompares++;
      end
      apply(32'd1, 32'd2, 6'b000001, 1'b1);
      vectors++;
      if (Z !== 32'hFFFFFFFF || V !== 1'b0 || S !== 1'b1) begin
         $display("FAIL sub_signed got Z=%h V=%b S=%b exp Z=FFFFFFFF V=0 S=1", Z, V, S);
         miscompares++;
      end
      apply(32'h80000000, 32'h00000001, 6'b000001, 1'b1);
      vectors++;
      if (Z !== 32'h7FFFFFFF || V !== 1'b1 || S !== 1'b0) begin
         $display("FAIL sub_signed_ovf got Z=%h V=%b S=%b exp Z=7FFFFFFF V=1 S=0", Z, V, S);
         miscompares++;
      end
      apply(32'hFFFFFFFF, 32'h00000001, 6'b000000, 1'b0);
      vectors++;
      if (Z !== 32'h0 || V !== 1'b1 || S !== 1'b0) begin
         $display("FAIL add_carry got Z=%h V=%b S=%b exp Z=0 V=1 S=0", Z, V, S);
         miscompares++;
      end
      apply(32'h00000002, 32'h00000001, 6'b000001, 1'b0);
      vectors++;
      if (Z !== 32'h1 || V !== 1'b0 || S !== 1'b0) begin
         $display("FAIL sub_no_borrow got Z=%h V=%b S=%b exp Z=1 V=0 S=0", Z, V, S);
         miscompares++;
      end
      apply(32'h12345678, 32'h0, 6'b000111, 1'b1);
      vectors++;
      if (Z !== 32'h0 || V !== 1'b0 || S !== 1'b0) begin
         $display("FAIL arith_unlisted got Z=%h V=%b S=%b exp 0", Z, V, S);
         miscompares++;
      end
   endtask

   task automatic test_reset_async;
      @(posedge clk);
      #2;
      vectors++;
      if (OvfSticky !== 1'b1) begin
         $display("FAIL rst_pre got=%b exp=1", OvfSticky);
         miscompares++;
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL rst_async got=%b exp=0", OvfSticky);
         miscompares++;
      end
      apply(32'h7FFFFFFF, 32'h7FFFFFFF, 6'b000000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (OvfSticky !== 1'b0) begin
         $display("FAIL rst_dominates got=%b exp=0", OvfSticky);
         miscompares++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (OvfSticky !== 1'b1) begin
         $display("FAIL rst_release_set got=%b exp=1", OvfSticky);
         miscompares++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      A           = 32'd0;
      B           = 32'd0;
      ALUFun      = 6'd0;
      Sign        = 1'b0;
      test_reset();
      test_logic();
      test_shift();
      test_compare();
      test_add_overflow();
      test_sub();
      test_reset_async();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
